iterative_shift_right: RTL and testbench
========================================

ITERATIVE_SHIFT_RIGHT -- requirements
Module: iterative_shift_right

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk (rising edge) and reset.
REQ-002 clk  input  1  system clock; all state changes on its rising edge.
REQ-003 reset  input  1  synchronous, active-high; sampled on the rising edge of clk.
REQ-004 start  input  1  request to begin an operation; honoured only in IDLE.
REQ-005 a  input  32  operand; captured on the accepting edge.
REQ-006 shift_amount  input  5  shift count N (0..31); captured on the accepting edge.
REQ-007 mode  input  2  operation select; captured on the accepting edge:
- 00: logical right.
- 01: arithmetic right.
- 10: rotate right.
- 11: rotate left.
REQ-008 result  output  32  registered result; holds its last value until the next completion.
REQ-009 busy  output  1  high whenever the state is not IDLE.
REQ-010 done  output  1  one-cycle completion pulse; result is valid while done is high and afterwards.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 IDLE with start=1 on edge k:
- capture a into the work register, N into the counter, and mode.
- go to SHIFT if N!=0; go to DONE if N=0.
REQ-013 IDLE with start=0: remain in IDLE with no register change except done=0.
REQ-014 SHIFT, on each edge:
- shift the work register by exactly one bit position according to the captured mode.
- decrement the counter.
- go to DONE on the edge where the counter goes from 1 to 0.
REQ-015 Per-bit operation:
- logical right: zero into bit 31.
- arithmetic right: the current bit 31 is replicated.
- rotate right: bit 0 into bit 31.
- rotate left: bit 31 into bit 0.
REQ-016 On entering DONE, result SHALL be loaded with the final work-register value and done SHALL be 1 for exactly that one cycle.
REQ-017 DONE SHALL always return to IDLE on the next edge, with done returning to 0.
REQ-018 Latency: with start sampled on edge k, done SHALL rise on edge k+N (N=0 gives done on edge k); busy SHALL be high for N+1 cycles.
REQ-019 Throughput: the next start is accepted no earlier than the edge after the DONE cycle, giving a minimum of N+2 cycles per operation.
REQ-020 start asserted in SHIFT or DONE SHALL be ignored; it is neither queued nor does it alter the operation in progress.
REQ-021 Changes on a, shift_amount or mode after the accepting edge SHALL NOT affect the operation in progress.
REQ-022 result SHALL equal a, unchanged, when N=0, for every mode.
REQ-023 All arithmetic SHALL be 32-bit with no width extension; the counter is 5 bits and never wraps below 0.

Reset
REQ-024 reset=1 on an edge SHALL force, regardless of state:
- state=IDLE
- result=32'h0
- busy=0
- done=0
- counter, work register and captured mode cleared.
REQ-025 reset SHALL take priority over start and over any in-progress operation; an aborted operation SHALL produce no done pulse.
REQ-026 The first edge with reset=0 SHALL behave as IDLE, so start asserted on that edge is accepted.

Verification
REQ-027 a=32'h80000000, N=4, mode=00 -> result=32'h08000000; done rises on edge k+4; busy high for 5 cycles.
REQ-028 a=32'h80000000, N=4, mode=01 -> result=32'hF8000000; also a=32'h7FFFFFFF, N=31, mode=01 -> result=32'h00000000.
REQ-029 a=32'h00000001, N=1, mode=10 -> result=32'h80000000; a=32'h80000001, N=31, mode=11 -> result=32'hC0000000.
REQ-030 a=32'hDEADBEEF, N=0, each mode -> result=32'hDEADBEEF with done on edge k; back-to-back starts are accepted every 2 cycles.
REQ-031 Start a=32'hFFFF0000, N=8, mode=00, then during SHIFT drive start=1, a=0 and N=1 -> those inputs are ignored; result=32'h00FFFF00 on edge k+8.
REQ-032 reset asserted for one edge at k+3 of an N=10 operation:
- result=0, busy=0, done=0 after that edge.
- no done pulse follows.
- a new start accepted on the next edge completes correctly.

Source files
------------

// File: rtl/iterative_shift_right.sv
// Multi-cycle 32-bit shifter/rotator: moves the operand one bit per clock
// and posts the final value to a held result register with a done pulse.
module iterative_shift_right (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] a,
    input  logic [4:0]  shift_amount,
    input  logic [1:0]  mode,
    output logic [31:0] result,
    output logic        busy,
    output logic        done
);

    // state  | meaning
    // IDLE   | waiting for start; operands captured on the accepting edge
    // SHIFT  | one-bit step per edge until the counter reaches zero
    // DONE   | result just loaded, done high for this single cycle
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] MODE_LSR = 2'b00;
    localparam logic [1:0] MODE_ASR = 2'b01;
    localparam logic [1:0] MODE_ROR = 2'b10;
    localparam logic [1:0] MODE_ROL = 2'b11;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_work;
    logic [4:0]  r_count;
    logic [1:0]  r_mode;
    logic [31:0] r_result;
    logic        r_done;
    logic [31:0] w_shifted;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_next_state = (shift_amount == 5'd0) ? S_DONE : S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (r_count == 5'd1) begin
                    w_next_state = S_DONE;
                end
            end
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_shifted = r_work;
        case (r_mode)
            MODE_LSR: w_shifted = {1'b0, r_work[31:1]};
            MODE_ASR: w_shifted = {r_work[31], r_work[31:1]};
            MODE_ROR: w_shifted = {r_work[0], r_work[31:1]};
            MODE_ROL: w_shifted = {r_work[30:0], r_work[31]};
            default:  w_shifted = r_work;
        endcase
    end

    // The final shift step writes straight into the result so done and result
    // appear on the same edge the counter reaches zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_work   <= 32'h0;
            r_count  <= 5'd0;
            r_mode   <= 2'b00;
            r_result <= 32'h0;
            r_done   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_work  <= a;
                        r_count <= shift_amount;
                        r_mode  <= mode;
                        if (shift_amount == 5'd0) begin
                            r_result <= a;
                            r_done   <= 1'b1;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    if (r_count != 5'd0) begin
                        r_count <= r_count - 5'd1;
                    end
                    if (r_count == 5'd1) begin
                        r_result <= w_shifted;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign busy   = (r_state != S_IDLE);

endmodule

// File: tb/tb_iterative_shift_right.sv
// Directed bench for iterative_shift_right: hand-computed results, done
// latency, busy length, input isolation and reset abort behaviour.
module tb_iterative_shift_right;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a;
    logic [4:0]  shift_amount;
    logic [1:0]  mode;
    logic [31:0] result;
    logic        busy;
    logic        done;

    int n_vec = 0;
    int n_mis = 0;

    iterative_shift_right dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .a            (a),
        .shift_amount (shift_amount),
        .mode         (mode),
        .result       (result),
        .busy         (busy),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    // Start one operation on the next edge (edge k) and follow it until busy
    // drops. With disturb set, bogus start/operands are driven during the run.
    task automatic run_op(input string tag, input logic [31:0] op_a, input logic [4:0] op_n,
                          input logic [1:0] op_mode, input logic [31:0] exp_res,
                          input bit disturb);
        int cyc;
        int busy_cnt;
        int done_cnt;
        int done_at;
        @(negedge clk);
        start        = 1'b1;
        a            = op_a;
        shift_amount = op_n;
        mode         = op_mode;
        @(posedge clk);
        #1;
        if (disturb) begin
            start        = 1'b1;
            a            = 32'h0;
            shift_amount = 5'd1;
            mode         = 2'b11;
        end else begin
            start = 1'b0;
        end
        cyc      = 0;
        busy_cnt = 0;
        done_cnt = 0;
        done_at  = -1;
        while (cyc < 40) begin
            if (!busy) break;
            busy_cnt++;
            if (done) begin
                done_cnt++;
                if (done_at < 0) done_at = cyc;
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;
        chk({tag, " result"}, result, exp_res);
        chk({tag, " done_edge"}, 32'(done_at), 32'(op_n));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(op_n) + 32'd1);
        chk({tag, " done_pulses"}, 32'(done_cnt), 32'd1);
        chk({tag, " result_held"}, result, exp_res);
    endtask

    // Start an N=10 operation and assert reset for the single edge k+3.
    task automatic abort_op();
        @(negedge clk);
        start        = 1'b1;
        a            = 32'hA5A5A5A5;
        shift_amount = 5'd10;
        mode         = 2'b00;
        @(posedge clk);
        #1;
        start = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort result", result, 32'h0);
        chk("abort busy", {31'b0, busy}, 32'h0);
        chk("abort done", {31'b0, done}, 32'h0);
    endtask

    initial begin
        int late_done;
        reset        = 1'b1;
        start        = 1'b0;
        a            = 32'h0;
        shift_amount = 5'd0;
        mode         = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        chk("reset result", result, 32'h0);
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        reset = 1'b0;

        // Reset released on this negedge; the very next edge accepts start.
        run_op("lsr4", 32'h80000000, 5'd4, 2'b00, 32'h08000000, 1'b0);
        run_op("asr4", 32'h80000000, 5'd4, 2'b01, 32'hF8000000, 1'b0);
        run_op("asr31", 32'h7FFFFFFF, 5'd31, 2'b01, 32'h00000000, 1'b0);
        run_op("ror1", 32'h00000001, 5'd1, 2'b10, 32'h80000000, 1'b0);
        run_op("rol31", 32'h80000001, 5'd31, 2'b11, 32'hC0000000, 1'b0);
        run_op("lsr31", 32'h80000000, 5'd31, 2'b00, 32'h00000001, 1'b0);
        run_op("ror4", 32'h12345678, 5'd4, 2'b10, 32'h81234567, 1'b0);
        run_op("rol4", 32'h12345678, 5'd4, 2'b11, 32'h23456781, 1'b0);
        run_op("asr3pos", 32'h40000008, 5'd3, 2'b01, 32'h08000001, 1'b0);

        // N=0 in every mode, issued back to back at the 2-cycle minimum.
        run_op("n0 lsr", 32'hDEADBEEF, 5'd0, 2'b00, 32'hDEADBEEF, 1'b0);
        run_op("n0 asr", 32'hDEADBEEF, 5'd0, 2'b01, 32'hDEADBEEF, 1'b0);
        run_op("n0 ror", 32'hDEADBEEF, 5'd0, 2'b10, 32'hDEADBEEF, 1'b0);
        run_op("n0 rol", 32'hDEADBEEF, 5'd0, 2'b11, 32'hDEADBEEF, 1'b0);

        run_op("disturb", 32'hFFFF0000, 5'd8, 2'b00, 32'h00FFFF00, 1'b1);

        abort_op();
        late_done = 0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) late_done++;
        end
        chk("abort no_done", 32'(late_done), 32'd0);

        abort_op();
        run_op("after_abort", 32'h000000F0, 5'd4, 2'b00, 32'h0000000F, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
